csr_exec_unit: RTL

// - Initiator side of the CSR request/response interface.
// - Accepts one CSR micro-op from the issue queue and waits until that micro-op is the ROB head.
// - Then issues exactly one request to the CSR file, captures the old CSR value and the exception flag,
//   and returns a writeback/completion packet to the ROB and the physical register file.
// - Serialising: at most one CSR micro-op in flight.

---
 rtl/csr_exec_unit_pkg.sv | 32 +++
 rtl/csr_exec_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/csr_exec_unit_pkg.sv
// rtl/csr_exec_unit_pkg.sv - CSR funct3 encodings, CSR request opcodes, exec FSM states
package csr_exec_unit_pkg;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_REQ,
        ST_RESP,
        ST_WB
    } state_e;

    typedef struct packed {
        csr_op_e     opcode;
        logic        wr_en;
        logic [31:0] data;
    } csr_req_t;

endpackage

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - serialising CSR micro-op executor between issue queue, CSR file and ROB
// Holds one micro-op, waits for ROB head, fires a single CSR request and returns a completion packet.
module csr_exec_unit
    import csr_exec_unit_pkg::*;
#(
    parameter int PRF_W = 6,
    parameter int ROB_W = 5
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_ni,
    input  logic             iss_valid_i,
    output logic             iss_ready_o,
    input  logic [2:0]       iss_funct3_i,
    input  logic [11:0]      iss_csr_addr_i,
    input  logic [31:0]      iss_rs1_data_i,
    input  logic [4:0]       iss_rs1_idx_i,
    input  logic [PRF_W-1:0] iss_rd_i,
    input  logic [ROB_W-1:0] iss_rob_id_i,
    input  logic [ROB_W-1:0] rob_head_id_i,
    input  logic             flush_i,
    output logic             csr_valid_o,
    output logic [11:0]      csr_addr_o,
    output logic [1:0]       csr_opcode_o,
    output logic             csr_wr_en_o,
    output logic [31:0]      csr_data_o,
    input  logic             csr_done_i,
    input  logic             csr_excp_i,
    input  logic [31:0]      csr_rdata_i,
    output logic             wb_valid_o,
    output logic [ROB_W-1:0] wb_rob_id_o,
    output logic [PRF_W-1:0] wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             wb_excp_o
);

    // Set/clear forms with a zero source are pure reads and must not touch the CSR.
    function automatic csr_req_t decode_req(input logic [2:0]  funct3,
                                            input logic [31:0] rs1_data,
                                            input logic [4:0]  rs1_idx);
        csr_req_t req;
        req.opcode = csr_op_e'(funct3[1:0]);
        req.data   = funct3[2] ? {27'b0, rs1_idx} : rs1_data;
        case (funct3)
            F3_RW, F3_RWI:                 req.wr_en = 1'b1;
            F3_RS, F3_RC, F3_RSI, F3_RCI:  req.wr_en = (rs1_idx != 5'd0);
            default:                       req.wr_en = 1'b0;
        endcase
        return req;
    endfunction

    state_e             r_state;
    state_e             w_next;
    csr_req_t           r_req;
    logic [11:0]        r_addr;
    logic [PRF_W-1:0]   r_rd;
    logic [ROB_W-1:0]   r_rob_id;
    logic [31:0]        r_wb_data;
    logic               r_wb_excp;
    logic               r_kill;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (iss_valid_i) w_next = ST_HEAD;
            ST_HEAD: begin
                if (flush_i)                         w_next = ST_IDLE;
                else if (rob_head_id_i == r_rob_id)  w_next = ST_REQ;
            end
            ST_REQ:  w_next = ST_RESP;
            ST_RESP: if (csr_done_i) w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            r_state   <= ST_IDLE;
            r_req     <= '{opcode: CSR_OP_NONE, wr_en: 1'b0, data: 32'd0};
            r_addr    <= 12'd0;
            r_rd      <= '0;
            r_rob_id  <= '0;
            r_wb_data <= 32'd0;
            r_wb_excp <= 1'b0;
            r_kill    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && iss_valid_i) begin
                r_req    <= decode_req(iss_funct3_i, iss_rs1_data_i, iss_rs1_idx_i);
                r_addr   <= iss_csr_addr_i;
                r_rd     <= iss_rd_i;
                r_rob_id <= iss_rob_id_i;
                r_kill   <= 1'b0;
            end
            // The request already took effect; a flush here only drops the completion.
            if (r_state == ST_RESP) begin
                if (flush_i) r_kill <= 1'b1;
                if (csr_done_i) begin
                    r_wb_data <= csr_excp_i ? 32'd0 : csr_rdata_i;
                    r_wb_excp <= csr_excp_i;
                end
            end
        end
    end

    assign iss_ready_o  = (r_state == ST_IDLE);
    assign csr_valid_o  = (r_state == ST_REQ);
    assign csr_addr_o   = r_addr;
    assign csr_opcode_o = r_req.opcode;
    assign csr_wr_en_o  = r_req.wr_en;
    assign csr_data_o   = r_req.data;
    assign wb_valid_o   = (r_state == ST_WB) && !r_kill && !flush_i;
    assign wb_rob_id_o  = r_rob_id;
    assign wb_rd_o      = r_rd;
    assign wb_data_o    = r_wb_data;
    assign wb_excp_o    = r_wb_excp;

endmodule
